exi_capture: RTL and testbench



---
 rtl/exi_capture.sv | 104 ++++++++++
 tb/tb_exi_capture.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/exi_capture.sv
// exi_capture: sniffs the EXI bus into MSB-first bytes and stores them in a buffer with a registered read port.
module exi_capture #(
  parameter int unsigned ADDR_W = 8,
  parameter bit STOP_ON_FULL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exi_clk,
  input  logic              exi_cs,
  input  logic              exi_data,
  input  logic              arm,
  input  logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic [ADDR_W-1:0] exi_addr_track,
  output logic              full,
  output logic [7:0]        frame_count,
  output logic [7:0]        drop_count
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic [1:0] {IDLE, ARMED, SHIFT, FULL} state_t;
  state_t state, state_n;
  logic [2:0] sck_s, cs_s, bit_cnt, bit_cnt_n;
  logic [1:0] dat_s;
  logic [7:0] shift, shift_n;
  logic [7:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic byte_done, byte_done_n, start, drop, wrap;
  logic sck_rise, cs_fall, cs_rise;
  always_ff @(negedge clk) begin
    sck_s <= {sck_s[1:0], exi_clk};
    cs_s  <= {cs_s[1:0], exi_cs};
    dat_s <= {dat_s[0], exi_data};
  end
  assign sck_rise = sck_s[1] & ~sck_s[2];
  assign cs_fall  = ~cs_s[1] & cs_s[2];
  assign cs_rise  = cs_s[1] & ~cs_s[2];
  assign wrap     = byte_done && (wr_ptr == '1);
  always_comb begin
    state_n = state;
    shift_n = shift;
    bit_cnt_n = bit_cnt;
    byte_done_n = 1'b0;
    start = 1'b0;
    drop = 1'b0;
    case (state)
      IDLE: state_n = arm ? ARMED : IDLE;
      ARMED: begin
        if (!arm) state_n = IDLE;
        else if (cs_fall) begin
          state_n = SHIFT;
          bit_cnt_n = '0;
          start = 1'b1;
        end
      end
      SHIFT: begin
        if (sck_rise) begin
          shift_n = {shift[6:0], dat_s[1]};
          bit_cnt_n = bit_cnt + 3'd1;
          byte_done_n = &bit_cnt;
        end
        // a bit arriving with cs_rise is shifted first, so a completing byte is not a drop
        if (cs_rise) begin
          drop = bit_cnt_n != 3'd0;
          bit_cnt_n = '0;
          state_n = arm ? ARMED : IDLE;
        end
      end
      default: ;
    endcase
    if (STOP_ON_FULL && wrap) begin
      state_n = FULL;
      start = 1'b0;
    end
  end
  always_ff @(negedge clk) begin
    if (rst) begin
      state <= IDLE;
      shift <= '0;
      bit_cnt <= '0;
      byte_done <= 1'b0;
      wr_ptr <= '0;
      exi_addr_track <= '1;
      full <= 1'b0;
      frame_count <= '0;
      drop_count <= '0;
      ram_data <= '0;
    end else begin
      state <= state_n;
      shift <= shift_n;
      bit_cnt <= bit_cnt_n;
      byte_done <= byte_done_n;
      frame_count <= start ? frame_count + 8'd1 : frame_count;
      drop_count <= (drop && drop_count != 8'hFF) ? drop_count + 8'd1 : drop_count;
      wr_ptr <= byte_done ? wr_ptr + ADDR_W'(1) : wr_ptr;
      exi_addr_track <= byte_done ? wr_ptr : exi_addr_track;
      full <= full | wrap;
      ram_data <= mem[ram_addr];
    end
  end
  // shift is stable during the write cycle because exi_clk runs at most clk/4
  always_ff @(negedge clk) begin
    if (!rst && byte_done) mem[wr_ptr] <= shift;
  end
endmodule

// File: tb/tb_exi_capture.sv
// tb_exi_capture: drives both wrap and stop-on-full builds, scoreboarding reads and status against a frame-level model.
module tb_exi_capture;
  logic clk = 1'b0, rst = 1'b0, exi_clk = 1'b0, exi_cs = 1'b1, exi_data = 1'b0, arm = 1'b0;
  logic [7:0] ram_addr = '0;
  logic [7:0] rd_w, trk_w, fc_w, dc_w, rd_s, trk_s, fc_s, dc_s;
  logic full_w, full_s;
  always #5 clk = ~clk;
  exi_capture #(.ADDR_W(8), .STOP_ON_FULL(1'b0)) dut_w (
    .clk(clk), .rst(rst), .exi_clk(exi_clk), .exi_cs(exi_cs), .exi_data(exi_data), .arm(arm),
    .ram_addr(ram_addr), .ram_data(rd_w), .exi_addr_track(trk_w), .full(full_w),
    .frame_count(fc_w), .drop_count(dc_w));
  exi_capture #(.ADDR_W(8), .STOP_ON_FULL(1'b1)) dut_s (
    .clk(clk), .rst(rst), .exi_clk(exi_clk), .exi_cs(exi_cs), .exi_data(exi_data), .arm(arm),
    .ram_addr(ram_addr), .ram_data(rd_s), .exi_addr_track(trk_s), .full(full_s),
    .frame_count(fc_s), .drop_count(dc_s));
  typedef struct {
    bit is_stat, rst_rd, v0, v1;
    logic [7:0] addr, rd0, rd1, trk0, trk1, fc0, fc1, dc0, dc1;
    bit f0, f1;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0;
  logic fire = 1'b0, fire_p = 1'b0;
  logic [7:0] m_mem [2][256];
  bit m_ok [2][256];
  int m_wr [2];
  logic [7:0] m_trk [2], m_fc [2], m_dc [2];
  bit m_full [2], m_frz [2];
  logic [7:0] fq[$];
  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h, expected %02h", nm, act, exp);
    end
  endtask
  always @(negedge clk) fire_p <= fire;
  always @(posedge clk) begin
    if (fire_p) begin
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: output with no expectation, expected queue entry");
      end else begin
        e = q.pop_front();
        if (e.is_stat) begin
          chk("trk_w", trk_w, e.trk0); chk("trk_s", trk_s, e.trk1);
          chk("full_w", {7'd0, full_w}, {7'd0, e.f0}); chk("full_s", {7'd0, full_s}, {7'd0, e.f1});
          chk("frames_w", fc_w, e.fc0); chk("frames_s", fc_s, e.fc1);
          chk("drops_w", dc_w, e.dc0); chk("drops_s", dc_s, e.dc1);
          if (e.rst_rd) begin
            chk("rst_rd_w", rd_w, 8'h00); chk("rst_rd_s", rd_s, 8'h00);
          end
        end else begin
          if (e.v0) chk($sformatf("rd_w[%02h]", e.addr), rd_w, e.rd0);
          if (e.v1) chk($sformatf("rd_s[%02h]", e.addr), rd_s, e.rd1);
        end
      end
    end
  end
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_wr[k] = 0; m_trk[k] = 8'hFF; m_fc[k] = 0; m_dc[k] = 0; m_full[k] = 0; m_frz[k] = 0;
    end
  endtask
  task automatic model_frame(bit cap, int pb);
    for (int k = 0; k < 2; k++) begin
      if (cap && !m_frz[k]) begin
        m_fc[k]++;
        foreach (fq[i]) begin
          if (!m_frz[k]) begin
            m_mem[k][m_wr[k]] = fq[i];
            m_ok[k][m_wr[k]] = 1;
            m_trk[k] = 8'(m_wr[k]);
            if (m_wr[k] == 255) begin
              m_full[k] = 1;
              if (k == 1) m_frz[k] = 1;
            end
            m_wr[k] = (m_wr[k] + 1) % 256;
          end
        end
        if (pb != 0 && !m_frz[k] && m_dc[k] != 8'hFF) m_dc[k]++;
      end
    end
  endtask
  task automatic issue(exp_t x);
    @(posedge clk);
    q.push_back(x);
    fire = 1'b1;
    @(posedge clk);
    fire = 1'b0;
  endtask
  task automatic stat_chk(bit rr = 0);
    exp_t x;
    x = '{is_stat: 1, rst_rd: rr, v0: 0, v1: 0, addr: 0, rd0: 0, rd1: 0,
          trk0: m_trk[0], trk1: m_trk[1], fc0: m_fc[0], fc1: m_fc[1],
          dc0: m_dc[0], dc1: m_dc[1], f0: m_full[0], f1: m_full[1]};
    issue(x);
  endtask
  task automatic read_chk(int a);
    exp_t x;
    ram_addr = 8'(a);
    x = '{is_stat: 0, rst_rd: 0, v0: m_ok[0][a], v1: m_ok[1][a], addr: 8'(a),
          rd0: m_mem[0][a], rd1: m_mem[1][a], trk0: 0, trk1: 0, fc0: 0, fc1: 0,
          dc0: 0, dc1: 0, f0: 0, f1: 0};
    issue(x);
  endtask
  task automatic bus_bits(logic [7:0] v, int n);
    for (int j = 0; j < n; j++) begin
      exi_data = v[7-j];
      #30 exi_clk = 1'b1;
      #30 exi_clk = 1'b0;
    end
  endtask
  task automatic send(int pb, logic [7:0] pv, int drop_at = -1);
    bit cap;
    cap = arm;
    exi_cs = 1'b0;
    #40;
    foreach (fq[i]) begin
      bus_bits(fq[i], 8);
      if (i == drop_at) arm = 1'b0;
    end
    if (pb != 0) bus_bits(pv, pb);
    #30 exi_cs = 1'b1;
    #100;
    model_frame(cap, pb);
  endtask
  task automatic do_reset();
    @(posedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    rst = 1'b0;
    model_reset();
    repeat (4) @(posedge clk);
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at 2ms, expected finish");
    $fatal(1);
  end
  initial begin
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 256; a++) m_ok[k][a] = 0;
    model_reset();
    @(posedge clk);
    rst = 1'b1;
    @(posedge clk);
    q.push_back('{is_stat: 1, rst_rd: 1, v0: 0, v1: 0, addr: 0, rd0: 0, rd1: 0,
                  trk0: 8'hFF, trk1: 8'hFF, fc0: 0, fc1: 0, dc0: 0, dc1: 0, f0: 0, f1: 0});
    fire = 1'b1;
    @(posedge clk);
    fire = 1'b0;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    arm = 1'b1;
    repeat (4) @(posedge clk);
    fq = '{8'hA5, 8'h3C, 8'hFF};
    send(0, 0);
    stat_chk();
    for (int a = 0; a < 3; a++) read_chk(a);
    fq = {};
    send(5, 8'hB8);
    stat_chk();
    fq = '{8'h81};
    send(0, 0);
    stat_chk();
    read_chk(3);
    for (int r = 0; r < 8; r++) begin
      arm = ($urandom_range(0, 3) != 0);
      repeat (4) @(posedge clk);
      fq = {};
      for (int i = 0, n = $urandom_range(0, 4); i < n; i++) fq.push_back(8'($urandom));
      send((fq.size() == 0) ? $urandom_range(1, 7) : $urandom_range(0, 7), 8'($urandom));
      stat_chk();
      if (m_trk[0] != 8'hFF) read_chk(m_trk[0]);
    end
    arm = 1'b0;
    repeat (4) @(posedge clk);
    fq = '{8'h11, 8'h22};
    send(0, 0);
    stat_chk();
    arm = 1'b1;
    repeat (4) @(posedge clk);
    fq = '{8'h5A, 8'hC3};
    send(0, 0, 0);
    fq = '{8'hEE};
    send(0, 0);
    stat_chk();
    read_chk(m_trk[0]);
    arm = 1'b1;
    repeat (4) @(posedge clk);
    exi_cs = 1'b0;
    #40;
    bus_bits(8'hF0, 4);
    do_reset();
    #30 exi_cs = 1'b1;
    #100;
    fq = '{8'h7E};
    send(0, 0);
    stat_chk();
    read_chk(0);
    do_reset();
    fq = {};
    for (int i = 0; i < 256; i++) fq.push_back(8'($urandom));
    send(0, 0);
    stat_chk();
    read_chk(0);
    read_chk(255);
    fq = '{8'h55};
    send(0, 0);
    stat_chk();
    read_chk(0);
    repeat (4) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d responses left unchecked, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
